// File: rtl/random_seq_pkg.sv
// Shared definitions for the 11-step pseudo-random count sequence
// 0-2-5-3-6-8-4-1-9-13-12: ordinal tables, successor and legality helpers.
package random_seq_pkg;

    localparam int unsigned SEQ_LEN  = 11;
    localparam logic [3:0]  IDX_NONE = 4'hF;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_e;

    function automatic logic [3:0] code_to_idx(input logic [3:0] c);
        logic [3:0] i;
        case (c)
            4'd0:    i = 4'd0;
            4'd2:    i = 4'd1;
            4'd5:    i = 4'd2;
            4'd3:    i = 4'd3;
            4'd6:    i = 4'd4;
            4'd8:    i = 4'd5;
            4'd4:    i = 4'd6;
            4'd1:    i = 4'd7;
            4'd9:    i = 4'd8;
            4'd13:   i = 4'd9;
            4'd12:   i = 4'd10;
            default: i = IDX_NONE;
        endcase
        return i;
    endfunction

    function automatic logic [3:0] idx_to_code(input logic [3:0] i);
        logic [3:0] c;
        case (i)
            4'd0:    c = 4'd0;
            4'd1:    c = 4'd2;
            4'd2:    c = 4'd5;
            4'd3:    c = 4'd3;
            4'd4:    c = 4'd6;
            4'd5:    c = 4'd8;
            4'd6:    c = 4'd4;
            4'd7:    c = 4'd1;
            4'd8:    c = 4'd9;
            4'd9:    c = 4'd13;
            4'd10:   c = 4'd12;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

    function automatic logic legal(input logic [3:0] c);
        return code_to_idx(c) != IDX_NONE;
    endfunction

    // Illegal codes have no successor; 0 is returned as a harmless default.
    function automatic logic [3:0] succ(input logic [3:0] c);
        logic [3:0] i;
        i = code_to_idx(c);
        if (i == IDX_NONE) begin
            return 4'd0;
        end
        return idx_to_code((i == 4'(SEQ_LEN - 1)) ? 4'd0 : i + 4'd1);
    endfunction

endpackage

// File: rtl/rand_seq_lut.sv
// Combinational decode of one sequence code: ordinal, legality and successor.
// Shared with the generator side of the link.
module rand_seq_lut (
    input  logic [3:0] code,
    output logic [3:0] idx,
    output logic       is_legal,
    output logic [3:0] next_code
);
    import random_seq_pkg::*;

    always_comb begin
        idx       = code_to_idx(code);
        is_legal  = legal(code);
        next_code = succ(code);
    end

endmodule

// File: rtl/random_seq_checker.sv
// Receive-side checker: decodes sampled codes, acquires lock on the sequence,
// then flywheel-tracks it and counts mismatches with a saturating counter.
module random_seq_checker #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned MAX_MISS = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_code,
    input  logic             clr_err,
    output logic [3:0]       index,
    output logic             index_vld,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);
    import random_seq_pkg::*;

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned XW = $clog2(MAX_MISS + 1);

    state_e           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [MW-1:0]    match_q, match_d;
    logic [XW-1:0]    miss_q, miss_d;
    logic [3:0]       index_q, index_d;
    logic             index_vld_q, index_vld_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [3:0] in_idx, prev_succ, lut_unused_next;
    logic       in_legal, hold, step_ok;

    rand_seq_lut u_lut (
        .code      (in_code),
        .idx       (in_idx),
        .is_legal  (in_legal),
        .next_code (lut_unused_next)
    );

    always_comb begin
        prev_succ = succ(prev_q);
        hold      = in_legal && (in_code == prev_q);
        step_ok   = in_legal && (in_code == prev_succ);

        state_d     = state_q;
        prev_d      = prev_q;
        match_d     = match_q;
        miss_d      = miss_q;
        index_d     = index_q;
        index_vld_d = 1'b0;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        err_count_d = err_count_q;

        if (in_valid) begin
            if (in_legal) begin
                index_d     = in_idx;
                index_vld_d = 1'b1;
            end
            // HUNT has no meaningful prev, so a repeat there still starts acquisition.
            case (state_q)
                HUNT: begin
                    if (in_legal) begin
                        prev_d  = in_code;
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (hold) begin
                        state_d = SYNC;
                    end else if (step_ok) begin
                        prev_d = in_code;
                        if (match_q + MW'(1) == MW'(LOCK_CNT)) begin
                            match_d = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else if (in_legal) begin
                        prev_d  = in_code;
                        match_d = '0;
                    end else begin
                        match_d = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (hold) begin
                        state_d = LOCKED;
                    end else if (step_ok) begin
                        prev_d = in_code;
                        miss_d = '0;
                        wrap_d = (prev_q == 4'd12);
                    end else begin
                        err_d  = 1'b1;
                        prev_d = in_legal ? in_code : prev_succ;
                        if (miss_q + XW'(1) == XW'(MAX_MISS)) begin
                            miss_d  = '0;
                            match_d = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_q + XW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_err) begin
            err_count_d = '0;
        end else if (err_d && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            index_q     <= '0;
            index_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            index_q     <= index_d;
            index_vld_q <= index_vld_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            err_count_q <= err_count_d;
        end
    end

    assign index     = index_q;
    assign index_vld = index_vld_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign wrap      = wrap_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_random_seq_checker.sv
// Bench for random_seq_checker: directed scenarios plus a randomized stream,
// all checked against an ordinal-arithmetic reference model.
module tb_random_seq_checker;

    localparam int LOCK_CNT = 3;
    localparam int MAX_MISS = 2;
    localparam int ERR_W    = 8;
    localparam int CNT_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [3:0]       in_code;
    logic             clr_err;
    logic [3:0]       index;
    logic             index_vld;
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    int seq [11] = '{0, 2, 5, 3, 6, 8, 4, 1, 9, 13, 12};

    // Model: mode 0=hunting, 1=acquiring, 2=locked; prev kept as an ordinal.
    int m_mode, m_prev, m_match, m_miss;
    int e_index, e_vld, e_locked, e_err, e_wrap, e_cnt;

    random_seq_checker #(
        .LOCK_CNT (LOCK_CNT),
        .MAX_MISS (MAX_MISS),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .clr_err   (clr_err),
        .index     (index),
        .index_vld (index_vld),
        .locked    (locked),
        .err       (err),
        .wrap      (wrap),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic int ord_of(input int c);
        for (int i = 0; i < 11; i++) begin
            if (seq[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_match = 0; m_miss = 0;
        e_index = 0; e_vld = 0; e_locked = 0; e_err = 0; e_wrap = 0; e_cnt = 0;
    endtask

    task automatic model_step(input int v, input int c, input int clr);
        int o, nxt;
        o   = ord_of(c);
        nxt = (m_prev + 1) % 11;
        e_vld = 0; e_err = 0; e_wrap = 0;
        if (v != 0) begin
            if (o >= 0) begin
                e_index = o;
                e_vld   = 1;
            end
            if (m_mode == 0) begin
                if (o >= 0) begin
                    m_prev = o; m_match = 0; m_mode = 1;
                end
            end else if (o >= 0 && o == m_prev) begin
                // repeated code: ignored
            end else if (m_mode == 1) begin
                if (o == nxt) begin
                    m_prev = o;
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_mode = 2; m_match = 0;
                    end
                end else if (o >= 0) begin
                    m_prev = o; m_match = 0;
                end else begin
                    m_mode = 0; m_match = 0;
                end
            end else begin
                if (o == nxt) begin
                    e_wrap = (m_prev == 10) ? 1 : 0;
                    m_prev = o;
                    m_miss = 0;
                end else begin
                    e_err  = 1;
                    m_prev = (o >= 0) ? o : nxt;
                    m_miss++;
                    if (m_miss == MAX_MISS) begin
                        m_mode = 0; m_miss = 0; m_match = 0;
                    end
                end
            end
        end
        if (clr != 0) e_cnt = 0;
        else if (e_err != 0 && e_cnt < CNT_MAX) e_cnt++;
        e_locked = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".index"},     int'(index),     e_index);
        check_eq({tag, ".index_vld"}, int'(index_vld), e_vld);
        check_eq({tag, ".locked"},    int'(locked),    e_locked);
        check_eq({tag, ".err"},       int'(err),       e_err);
        check_eq({tag, ".wrap"},      int'(wrap),      e_wrap);
        check_eq({tag, ".err_count"}, int'(err_count), e_cnt);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input int v, input int c, input int clr, input string tag);
        in_valid = v[0];
        in_code  = c[3:0];
        clr_err  = clr[0];
        @(posedge clk);
        model_step(v, c, clr);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic feed(input int c, input string tag);
        step(1, c, 0, tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_code  = 4'd0;
        clr_err  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst");
        reset = 1'b1;

        // 1: acquisition from reset
        feed(0, "s1");
        feed(2, "s1");
        feed(5, "s1");
        check_eq("s1.not_yet_locked", int'(locked), 0);
        feed(3, "s1");
        check_eq("s1.locked_after_4", int'(locked), 1);
        feed(6, "s1");
        check_eq("s1.index4", int'(index), 4);

        // 2: wrap 12->0 while locked
        feed(8, "s2"); feed(4, "s2"); feed(1, "s2");
        feed(9, "s2"); feed(13, "s2"); feed(12, "s2");
        check_eq("s2.no_wrap_yet", int'(wrap), 0);
        feed(0, "s2");
        check_eq("s2.wrap_on_0", int'(wrap), 1);
        feed(2, "s2");
        check_eq("s2.wrap_once", int'(wrap), 0);
        check_eq("s2.no_err", int'(err_count), 0);

        // 3: single legal mismatch resyncs prev
        feed(5, "s3"); feed(3, "s3"); feed(6, "s3");
        feed(4, "s3");
        check_eq("s3.err_on_4", int'(err), 1);
        feed(1, "s3");
        check_eq("s3.no_err_on_1", int'(err), 0);
        check_eq("s3.err_count", int'(err_count), 1);
        check_eq("s3.still_locked", int'(locked), 1);

        // 4: two illegal codes drop lock; index holds ordinal of code 1
        feed(7, "s4");
        check_eq("s4.err_7", int'(err), 1);
        check_eq("s4.index_hold", int'(index), 7);
        feed(11, "s4");
        check_eq("s4.err_11", int'(err), 1);
        check_eq("s4.unlocked", int'(locked), 0);
        check_eq("s4.err_count", int'(err_count), 3);
        check_eq("s4.index_hold2", int'(index), 7);

        // 5: repeats are ignored; clear beats a simultaneous err
        feed(12, "s5"); feed(0, "s5"); feed(2, "s5"); feed(5, "s5");
        check_eq("s5.locked", int'(locked), 1);
        for (int i = 0; i < 3; i++) begin
            feed(5, "s5rep");
            check_eq("s5.rep_no_err", int'(err), 0);
        end
        step(1, 4, 1, "s5clr");
        check_eq("s5.clr_err_pulse", int'(err), 1);
        check_eq("s5.clr_wins", int'(err_count), 0);
        feed(1, "s5");

        // 6: saturate the error counter, then async reset mid-stream
        for (int k = 0; k < 260; k++) begin
            feed(seq[(m_prev + 3) % 11], "s6bad");
            feed(seq[(m_prev + 1) % 11], "s6good");
        end
        check_eq("s6.saturated", int'(err_count), CNT_MAX);
        check_eq("s6.locked", int'(locked), 1);
        feed(seq[(m_prev + 1) % 11], "s6");
        async_reset("s6arst");
        check_eq("s6.arst_locked", int'(locked), 0);
        check_eq("s6.arst_count", int'(err_count), 0);

        // Randomized stream: mostly correct successors, some repeats and noise
        for (int i = 0; i < 3000; i++) begin
            int v, r, c, clr;
            v   = ($urandom_range(0, 7) != 0) ? 1 : 0;
            r   = $urandom_range(0, 9);
            c   = (r < 7) ? seq[(m_prev + 1) % 11] :
                  (r == 7) ? seq[m_prev] : int'($urandom_range(0, 15));
            clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
            step(v, c, clr, "rnd");
            if (i == 1500) async_reset("rnd_arst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
